// File: rtl/huffman_pkg.sv
// Shared parameters, FSM state encoding and table types for the canonical
// Huffman decoder.
package huffman_pkg;
  localparam int SYM_W   = 4;
  localparam int NSYM    = 16;
  localparam int MAX_LEN = 15;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BUILD,
    ST_READY,
    ST_DECODE,
    ST_ERR
  } state_t;

  typedef logic [NSYM-1:0][LEN_W-1:0] len_tbl_t;
  typedef logic [NSYM-1:0][CNT_W-1:0] cnt_tbl_t;
  typedef logic [NSYM-1:0][SYM_W-1:0] sym_tbl_t;
endpackage

// File: rtl/huffman_canon_table.sv
// Code-length table plus the canonical table builder: a 15x16 sweep that
// fills cnt[] and sorted[] and runs the Kraft check, ending in a done/err pulse.
module huffman_canon_table
  import huffman_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [SYM_W-1:0] wr_sym_i,
  input  logic [LEN_W-1:0] wr_len_i,
  input  logic             go_i,
  output logic             build_done_o,
  output logic             build_err_o,
  output cnt_tbl_t         cnt_o,
  output sym_tbl_t         sorted_o
);
  len_tbl_t            len_q;
  cnt_tbl_t            cnt_q;
  sym_tbl_t            sorted_q;
  logic                busy_q;
  logic [LEN_W-1:0]    row_q;
  logic [SYM_W-1:0]    col_q;
  logic [SYM_W-1:0]    ptr_q;
  logic signed [23:0]  left_q;
  logic                done_q;
  logic                err_q;

  logic                hit;
  logic [CNT_W-1:0]    row_cnt;
  logic signed [23:0]  left_d;

  // row_cnt already includes the current column so the Kraft update at the
  // end of a row sees the complete count for that length.
  always_comb begin
    hit     = (len_q[col_q] == row_q);
    row_cnt = cnt_q[row_q] + CNT_W'(hit);
    left_d  = (left_q <<< 1) - $signed({19'd0, row_cnt});
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      len_q    <= '0;
      cnt_q    <= '0;
      sorted_q <= '0;
      busy_q   <= 1'b0;
      row_q    <= 4'd1;
      col_q    <= '0;
      ptr_q    <= '0;
      left_q   <= 24'sd1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (we_i) len_q[wr_sym_i] <= wr_len_i;
      if (go_i) begin
        busy_q <= 1'b1;
        row_q  <= 4'd1;
        col_q  <= '0;
        ptr_q  <= '0;
        left_q <= 24'sd1;
        cnt_q  <= '0;
        err_q  <= 1'b0;
      end else if (busy_q) begin
        if (hit) begin
          sorted_q[ptr_q] <= col_q;
          cnt_q[row_q]    <= row_cnt;
          ptr_q           <= ptr_q + 1'b1;
        end
        col_q <= col_q + 1'b1;
        if (col_q == SYM_W'(NSYM-1)) begin
          left_q <= left_d;
          if (row_q == LEN_W'(MAX_LEN)) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            err_q  <= (left_d < 0);
          end else begin
            row_q <= row_q + 1'b1;
          end
        end
      end
    end
  end

  assign build_done_o = done_q;
  assign build_err_o  = err_q;
  assign cnt_o        = cnt_q;
  assign sorted_o     = sorted_q;
endmodule

// File: rtl/huffman_decoder.sv
// Serial canonical-Huffman decoder: control FSM and the bit-serial
// code/first/index datapath, one stream bit per cycle.
module huffman_decoder
  import huffman_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             tbl_wr,
  input  logic [SYM_W-1:0] tbl_sym,
  input  logic [3:0]       tbl_len,
  input  logic             tbl_go,
  input  logic             in_start,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             in_last,
  output logic [SYM_W-1:0] out_data,
  output logic             out_valid,
  output logic             done,
  output logic             ready,
  output logic             err
);
  state_t           state_q;
  logic [15:0]      code_q, first_q, index_q;
  logic [3:0]       len_q;
  logic [SYM_W-1:0] out_data_q;
  logic             out_valid_q, done_q, ready_q, err_q;

  logic             build_done, build_err;
  cnt_tbl_t         cnt_tbl;
  sym_tbl_t         sorted_tbl;

  logic             tbl_we, tbl_go_en, bit_acc, hit, ovf;
  logic [15:0]      code_b, first_b, index_b, c, diff, cnt_l;
  logic [3:0]       len_b;
  logic [15:0]      code_d, first_d, index_d;
  logic [3:0]       len_d;
  logic [SYM_W-1:0] sidx, sym_d;

  huffman_canon_table u_table (
    .clk_i        (CLK),
    .rst_i        (RST),
    .we_i         (tbl_we),
    .wr_sym_i     (tbl_sym),
    .wr_len_i     (tbl_len),
    .go_i         (tbl_go_en),
    .build_done_o (build_done),
    .build_err_o  (build_err),
    .cnt_o        (cnt_tbl),
    .sorted_o     (sorted_tbl)
  );

  // in_start clears the partial codeword before the same-cycle bit is used.
  always_comb begin
    tbl_we    = tbl_wr && (state_q == ST_IDLE || state_q == ST_READY || state_q == ST_ERR);
    tbl_go_en = tbl_go && (state_q == ST_IDLE);
    bit_acc   = in_valid && (state_q == ST_READY || state_q == ST_DECODE) && !tbl_we;
    code_b    = in_start ? 16'd0 : code_q;
    first_b   = in_start ? 16'd0 : first_q;
    index_b   = in_start ? 16'd0 : index_q;
    len_b     = in_start ? 4'd1  : len_q;
    cnt_l     = {11'd0, cnt_tbl[len_b]};
    c         = (code_b << 1) | {15'd0, in_bit};
    diff      = c - first_b;
    hit       = (diff < cnt_l);
    sidx      = index_b[SYM_W-1:0] + diff[SYM_W-1:0];
    sym_d     = sorted_tbl[sidx];
    ovf       = !hit && (len_b == 4'(MAX_LEN));
    index_d   = index_b + cnt_l;
    first_d   = (first_b + cnt_l) << 1;
    code_d    = c;
    len_d     = len_b + 4'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      code_q      <= '0;
      first_q     <= '0;
      index_q     <= '0;
      len_q       <= 4'd1;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        ST_IDLE: if (tbl_go_en) state_q <= ST_BUILD;
        ST_BUILD: begin
          if (build_done) begin
            if (build_err) begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
            end else begin
              state_q <= ST_READY;
              ready_q <= 1'b1;
              code_q  <= '0;
              first_q <= '0;
              index_q <= '0;
              len_q   <= 4'd1;
            end
          end
        end
        ST_READY, ST_DECODE: begin
          if (tbl_we) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
          end else if (bit_acc) begin
            if (hit) begin
              out_valid_q <= 1'b1;
              out_data_q  <= sym_d;
              done_q      <= in_last;
              state_q     <= ST_READY;
              code_q      <= '0;
              first_q     <= '0;
              index_q     <= '0;
              len_q       <= 4'd1;
            end else if (ovf || in_last) begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
              ready_q <= 1'b0;
            end else begin
              state_q <= ST_DECODE;
              code_q  <= code_d;
              first_q <= first_d;
              index_q <= index_d;
              len_q   <= len_d;
            end
          end else if (in_start) begin
            state_q <= ST_READY;
            code_q  <= '0;
            first_q <= '0;
            index_q <= '0;
            len_q   <= 4'd1;
          end
        end
        ST_ERR: begin
          if (tbl_we) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign ready     = ready_q;
  assign err       = err_q;
endmodule

// File: tb/tb_huffman_decoder.sv
// Directed bench for huffman_decoder: a vector table for the complete-code
// stream plus hand-written sequences for build errors, truncation and reset.
module tb_huffman_decoder;
  logic       CLK = 1'b0;
  logic       RST, tbl_wr, tbl_go, in_start, in_valid, in_bit, in_last;
  logic [3:0] tbl_sym, tbl_len, out_data;
  logic       out_valid, done, ready, err;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  huffman_decoder dut (
    .CLK(CLK), .RST(RST), .tbl_wr(tbl_wr), .tbl_sym(tbl_sym), .tbl_len(tbl_len),
    .tbl_go(tbl_go), .in_start(in_start), .in_valid(in_valid), .in_bit(in_bit),
    .in_last(in_last), .out_data(out_data), .out_valid(out_valid), .done(done),
    .ready(ready), .err(err)
  );

  typedef struct {
    logic       start;
    logic       bitv;
    logic       last;
    logic       exp_v;
    logic [3:0] exp_d;
    logic       exp_done;
  } vec_t;

  vec_t                vecs[17];
  logic [15:0][3:0]    comp_lens, over_lens, inc_lens;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs;
    tbl_wr = 0; tbl_go = 0; tbl_sym = 0; tbl_len = 0;
    in_start = 0; in_valid = 0; in_bit = 0; in_last = 0;
  endtask

  task automatic do_reset;
    idle_inputs();
    RST = 1;
    tick();
    RST = 0;
  endtask

  task automatic load(input logic [15:0][3:0] lens);
    for (int s = 0; s < 16; s++) begin
      tbl_wr = 1; tbl_sym = 4'(s); tbl_len = lens[s];
      tick();
    end
    tbl_wr = 0;
  endtask

  task automatic build(input string name, input logic exp_ready);
    int n;
    tbl_go = 1;
    tick();
    tbl_go = 0;
    n = 0;
    while (!ready && !err && n < 400) begin
      tick();
      n++;
    end
    chk({name, "_cycles"}, 16'(n), 16'd241);
    chk({name, "_ready"}, {15'd0, ready}, {15'd0, exp_ready});
    chk({name, "_err"}, {15'd0, err}, {15'd0, !exp_ready});
  endtask

  task automatic send(input logic st, input logic b, input logic lst);
    in_start = st; in_valid = 1; in_bit = b; in_last = lst;
    tick();
    in_start = 0; in_valid = 0; in_last = 0;
  endtask

  task automatic write_one(input logic [3:0] s, input logic [3:0] l);
    tbl_wr = 1; tbl_sym = s; tbl_len = l;
    tick();
    tbl_wr = 0;
  endtask

  initial begin
    comp_lens = '0; comp_lens[0] = 4'd1; comp_lens[1] = 4'd2; comp_lens[2] = 4'd3; comp_lens[3] = 4'd3;
    over_lens = '0; over_lens[0] = 4'd1; over_lens[1] = 4'd1; over_lens[2] = 4'd1;
    inc_lens  = '0; inc_lens[5]  = 4'd1;

    // codes: 0 -> "0", 1 -> "10", 2 -> "110", 3 -> "111"
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd3, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b1};

    // reset state
    do_reset();
    chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_out_data", {12'd0, out_data}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_ready", {15'd0, ready}, 16'd0);
    chk("rst_err", {15'd0, err}, 16'd0);

    // complete code, table-driven stream
    load(comp_lens);
    build("complete", 1'b1);
    for (int i = 0; i < 17; i++) begin
      send(vecs[i].start, vecs[i].bitv, vecs[i].last);
      chk($sformatf("vec%0d_valid", i), {15'd0, out_valid}, {15'd0, vecs[i].exp_v});
      if (vecs[i].exp_v) chk($sformatf("vec%0d_data", i), {12'd0, out_data}, {12'd0, vecs[i].exp_d});
      chk($sformatf("vec%0d_done", i), {15'd0, done}, {15'd0, vecs[i].exp_done});
      chk($sformatf("vec%0d_err", i), {15'd0, err}, 16'd0);
      chk($sformatf("vec%0d_ready", i), {15'd0, ready}, 16'd1);
    end

    // in_start alone abandons a partial codeword: "1" | start | "10" -> 1
    send(1'b0, 1'b1, 1'b0);
    in_start = 1;
    tick();
    in_start = 0;
    chk("start_only_err", {15'd0, err}, 16'd0);
    send(1'b0, 1'b1, 1'b0);
    send(1'b0, 1'b0, 1'b0);
    chk("start_only_valid", {15'd0, out_valid}, 16'd1);
    chk("start_only_data", {12'd0, out_data}, 16'd1);

    // table write in READY drops ready
    write_one(4'd4, 4'd0);
    chk("wr_ready_drop", {15'd0, ready}, 16'd0);
    chk("wr_ready_err", {15'd0, err}, 16'd0);

    // truncated stream
    build("rebuild1", 1'b1);
    send(1'b0, 1'b1, 1'b0);
    send(1'b0, 1'b1, 1'b1);
    chk("trunc_err", {15'd0, err}, 16'd1);
    chk("trunc_done", {15'd0, done}, 16'd0);
    chk("trunc_valid", {15'd0, out_valid}, 16'd0);
    chk("trunc_ready", {15'd0, ready}, 16'd0);

    // table write leaves ERR
    write_one(4'd4, 4'd0);
    chk("wr_err_clear", {15'd0, err}, 16'd0);
    chk("wr_err_ready", {15'd0, ready}, 16'd0);

    // reset mid-decode
    build("rebuild2", 1'b1);
    send(1'b0, 1'b1, 1'b0);
    send(1'b0, 1'b1, 1'b0);
    send(1'b0, 1'b1, 1'b0);
    chk("pre_rst_data", {12'd0, out_data}, 16'd3);
    send(1'b0, 1'b1, 1'b0);
    send(1'b0, 1'b1, 1'b0);
    do_reset();
    chk("midrst_data", {12'd0, out_data}, 16'd0);
    chk("midrst_valid", {15'd0, out_valid}, 16'd0);
    chk("midrst_done", {15'd0, done}, 16'd0);
    chk("midrst_ready", {15'd0, ready}, 16'd0);
    chk("midrst_err", {15'd0, err}, 16'd0);
    load(comp_lens);
    build("after_rst", 1'b1);
    send(1'b0, 1'b1, 1'b0);
    send(1'b0, 1'b1, 1'b0);
    send(1'b0, 1'b0, 1'b1);
    chk("after_rst_valid", {15'd0, out_valid}, 16'd1);
    chk("after_rst_data", {12'd0, out_data}, 16'd2);
    chk("after_rst_done", {15'd0, done}, 16'd1);

    // oversubscribed table
    do_reset();
    load(over_lens);
    build("over", 1'b0);
    send(1'b0, 1'b0, 1'b0);
    send(1'b0, 1'b0, 1'b1);
    chk("over_valid", {15'd0, out_valid}, 16'd0);
    chk("over_done", {15'd0, done}, 16'd0);
    chk("over_err_hold", {15'd0, err}, 16'd1);
    chk("over_ready", {15'd0, ready}, 16'd0);

    // incomplete code: only symbol 5, code "0"
    do_reset();
    load(inc_lens);
    build("incomplete", 1'b1);
    send(1'b0, 1'b0, 1'b0);
    chk("inc_valid", {15'd0, out_valid}, 16'd1);
    chk("inc_data", {12'd0, out_data}, 16'd5);
    for (int i = 1; i <= 15; i++) begin
      send(1'b0, 1'b1, 1'b0);
      chk($sformatf("inc_one%0d_valid", i), {15'd0, out_valid}, 16'd0);
      chk($sformatf("inc_one%0d_err", i), {15'd0, err}, (i == 15) ? 16'd1 : 16'd0);
    end
    chk("inc_ready", {15'd0, ready}, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
